// File: rtl/debug_uart_bridge.sv
// debug_uart_bridge
// Turns a host byte stream from a UART receiver into timed bus cycles on the
// 8-bit debug port. Read data, write ACKs and command NAKs go back to the
// UART transmitter.
//
// Ports:
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   RX_DATA/VALID/READY   inbound byte stream (held by upstream until accepted)
//   TX_DATA/VALID/READY   outbound byte stream (held stable until accepted)
//   DBG_DOUT, DBG_DIN     debug port write data / read data
//   DBG_ADDR              debug register address
//   DBG_WRN, DBG_RDN      active-low write / read strobes (registered)
//   BUSY                  high whenever the command FSM is not idle
//   CMD_ERR, TIMEOUT_ERR  sticky error flags, cleared by CLR_ERR
//
// Command byte: bit7 = read(1)/write(0), bits6:3 must be zero, bits2:0 = address.
// A write command is followed by exactly one data byte.
module debug_uart_bridge #(
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter bit          ACK_WRITES     = 1'b1,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic       RX_READY,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY,
    output logic [7:0] DBG_DOUT,
    input  logic [7:0] DBG_DIN,
    output logic [2:0] DBG_ADDR,
    output logic       DBG_WRN,
    output logic       DBG_RDN,
    output logic       BUSY,
    output logic       CMD_ERR,
    output logic       TIMEOUT_ERR,
    input  logic       CLR_ERR
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WAIT_DATA = 4'd1,
        WR_SETUP  = 4'd2,
        WR_STROBE = 4'd3,
        WR_HOLD   = 4'd4,
        RD_SETUP  = 4'd5,
        RD_STROBE = 4'd6,
        RD_HOLD   = 4'd7,
        SEND      = 4'd8
    } state_t;

    // Phase counters run 0..N-1, so the phase ends when the count hits N-1.
    localparam logic [7:0]  SETUP_LAST   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0]  STROBE_LAST  = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST    = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic [15:0] to_cnt_r, to_cnt_nxt_s;
    logic        rx_ready_r, rx_fire_s, cmd_bad_s;
    logic [7:0]  tx_data_r, tx_data_nxt_s;
    logic        tx_valid_r;
    logic [7:0]  dout_r, dout_nxt_s;
    logic [2:0]  addr_r, addr_nxt_s;
    logic        wrn_r, rdn_r, busy_r;
    logic        cmd_err_r, to_err_r, cmd_err_set_s, to_err_set_s;

    assign rx_fire_s = RX_VALID & rx_ready_r;
    assign cmd_bad_s = (RX_DATA[6:3] != 4'b0000);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: command decode and phase sequencing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_fire_s) begin
                    if (cmd_bad_s)       state_nxt_s = SEND;
                    else if (RX_DATA[7]) state_nxt_s = RD_SETUP;
                    else                 state_nxt_s = WAIT_DATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_DATA: begin
                // A byte arriving on the last allowed cycle still wins.
                if (rx_fire_s)                     state_nxt_s = WR_SETUP;
                else if (to_cnt_r == TIMEOUT_LAST) state_nxt_s = IDLE;
                else                               state_nxt_s = WAIT_DATA;
            end
            WR_SETUP:  state_nxt_s = (cnt_r == SETUP_LAST)  ? WR_STROBE : WR_SETUP;
            WR_STROBE: state_nxt_s = (cnt_r == STROBE_LAST) ? WR_HOLD   : WR_STROBE;
            WR_HOLD: begin
                if (cnt_r == HOLD_LAST) state_nxt_s = ACK_WRITES ? SEND : IDLE;
                else                    state_nxt_s = WR_HOLD;
            end
            RD_SETUP:  state_nxt_s = (cnt_r == SETUP_LAST)  ? RD_STROBE : RD_SETUP;
            RD_STROBE: state_nxt_s = (cnt_r == STROBE_LAST) ? RD_HOLD   : RD_STROBE;
            RD_HOLD:   state_nxt_s = (cnt_r == HOLD_LAST)   ? SEND      : RD_HOLD;
            SEND:      state_nxt_s = TX_READY ? IDLE : SEND;
            default:   state_nxt_s = IDLE;
        endcase
    end

    // Output/datapath next values; strobes and flags are derived from the
    // next state so the registered outputs line up with the state register.
    always_comb begin
        tx_data_nxt_s = tx_data_r;
        addr_nxt_s    = addr_r;
        dout_nxt_s    = dout_r;
        cmd_err_set_s = 1'b0;
        to_err_set_s  = 1'b0;
        cnt_nxt_s     = 8'd0;
        to_cnt_nxt_s  = 16'd0;
        case (state_r)
            IDLE: begin
                if (rx_fire_s && cmd_bad_s) begin
                    cmd_err_set_s = 1'b1;
                    tx_data_nxt_s = NAK_BYTE;
                end else if (rx_fire_s) begin
                    addr_nxt_s = RX_DATA[2:0];
                end else begin
                    addr_nxt_s = addr_r;
                end
            end
            WAIT_DATA: begin
                if (rx_fire_s) begin
                    dout_nxt_s = RX_DATA;
                end else if (to_cnt_r == TIMEOUT_LAST) begin
                    to_err_set_s = 1'b1;
                end else begin
                    to_cnt_nxt_s = to_cnt_r + 16'd1;
                end
            end
            RD_STROBE: begin
                // Sample read data on the edge that ends the last low cycle.
                if (cnt_r == STROBE_LAST) tx_data_nxt_s = DBG_DIN;
                else                      tx_data_nxt_s = tx_data_r;
            end
            WR_HOLD: begin
                if (cnt_r == HOLD_LAST) tx_data_nxt_s = ACK_BYTE;
                else                    tx_data_nxt_s = tx_data_r;
            end
            default: begin
                tx_data_nxt_s = tx_data_r;
            end
        endcase
        // Phase counter restarts on every state change.
        if (state_nxt_s == state_r && state_r != IDLE && state_r != WAIT_DATA && state_r != SEND) begin
            cnt_nxt_s = cnt_r + 8'd1;
        end else begin
            cnt_nxt_s = 8'd0;
        end
    end

    // Registered outputs, counters and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r      <= 8'd0;
            to_cnt_r   <= 16'd0;
            rx_ready_r <= 1'b1;
            tx_data_r  <= 8'd0;
            tx_valid_r <= 1'b0;
            dout_r     <= 8'd0;
            addr_r     <= 3'd0;
            wrn_r      <= 1'b1;
            rdn_r      <= 1'b1;
            busy_r     <= 1'b0;
            cmd_err_r  <= 1'b0;
            to_err_r   <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            to_cnt_r   <= to_cnt_nxt_s;
            rx_ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == WAIT_DATA);
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= (state_nxt_s == SEND);
            dout_r     <= dout_nxt_s;
            addr_r     <= addr_nxt_s;
            wrn_r      <= (state_nxt_s != WR_STROBE);
            rdn_r      <= (state_nxt_s != RD_STROBE);
            busy_r     <= (state_nxt_s != IDLE);
            // A new error on the same edge as CLR_ERR takes precedence.
            cmd_err_r  <= cmd_err_set_s | (cmd_err_r & ~CLR_ERR);
            to_err_r   <= to_err_set_s  | (to_err_r  & ~CLR_ERR);
        end
    end

    assign RX_READY    = rx_ready_r;
    assign TX_DATA     = tx_data_r;
    assign TX_VALID    = tx_valid_r;
    assign DBG_DOUT    = dout_r;
    assign DBG_ADDR    = addr_r;
    assign DBG_WRN     = wrn_r;
    assign DBG_RDN     = rdn_r;
    assign BUSY        = busy_r;
    assign CMD_ERR     = cmd_err_r;
    assign TIMEOUT_ERR = to_err_r;

endmodule

// File: tb/tb_debug_uart_bridge.sv
// Bench for debug_uart_bridge: directed command sequences, a transaction-level
// reference model compared every cycle, and hand-computed literal expectations.
module tb_debug_uart_bridge;

    localparam int S  = 4;
    localparam int T  = 4;
    localparam int H  = 4;
    localparam int TO = 20;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] RX_DATA = 8'd0;
    logic       RX_VALID = 1'b0;
    logic       RX_READY;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY = 1'b1;
    logic [7:0] DBG_DOUT;
    logic [7:0] DBG_DIN = 8'd0;
    logic [2:0] DBG_ADDR;
    logic       DBG_WRN, DBG_RDN, BUSY, CMD_ERR, TIMEOUT_ERR;
    logic       CLR_ERR = 1'b0;

    debug_uart_bridge #(
        .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H),
        .TIMEOUT_CYCLES(TO), .ACK_WRITES(1'b1),
        .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .DBG_DOUT(DBG_DOUT), .DBG_DIN(DBG_DIN), .DBG_ADDR(DBG_ADDR),
        .DBG_WRN(DBG_WRN), .DBG_RDN(DBG_RDN), .BUSY(BUSY),
        .CMD_ERR(CMD_ERR), .TIMEOUT_ERR(TIMEOUT_ERR), .CLR_ERR(CLR_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: phase 0 idle, 1 awaiting write data, 2 bus op, 3 sending.
    int         m_phase = 0;
    int         m_t0 = 0;
    int         m_wait = 0;
    logic       m_rd = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] e_txd = 8'd0, e_dout = 8'd0;
    logic [2:0] e_addr = 3'd0;
    logic       e_cerr = 1'b0, e_terr = 1'b0;
    logic       e_wrn = 1'b1, e_rdn = 1'b1, e_txv = 1'b0, e_busy = 1'b0, e_rxr = 1'b1;

    // Strobe / TX monitors, sampled on the falling edge.
    int wr_low = 0, rd_low = 0, wr_first = -1, rd_first = -1, txv_cnt = 0;

    // Model: bus op timing is pure offset arithmetic from the op start edge.
    always @(posedge CLK) begin : model
        int  k;
        logic set_c, set_t;
        cyc++;
        set_c = 1'b0;
        set_t = 1'b0;
        if (RESET) begin
            m_phase = 0; e_txd = 8'd0; e_dout = 8'd0; e_addr = 3'd0;
            e_cerr = 1'b0; e_terr = 1'b0;
        end else begin
            case (m_phase)
                0: if (RX_VALID) begin
                    if (RX_DATA[6:3] != 4'd0) begin
                        set_c = 1'b1; e_txd = 8'h15; m_phase = 3;
                    end else begin
                        e_addr = RX_DATA[2:0];
                        if (RX_DATA[7]) begin m_rd = 1'b1; m_t0 = cyc; m_phase = 2; end
                        else begin m_phase = 1; m_wait = 0; end
                    end
                end
                1: if (RX_VALID) begin
                    e_dout = RX_DATA; m_rd = 1'b0; m_t0 = cyc; m_phase = 2;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin set_t = 1'b1; m_phase = 0; end
                end
                2: begin
                    k = cyc - m_t0;
                    if (m_rd && k == S + T) e_txd = DBG_DIN;
                    if (k == S + T + H) begin
                        if (!m_rd) e_txd = 8'h06;
                        m_phase = 3;
                    end
                end
                3: if (TX_READY) m_phase = 0;
                default: m_phase = 0;
            endcase
            e_cerr = set_c | (e_cerr & ~CLR_ERR);
            e_terr = set_t | (e_terr & ~CLR_ERR);
        end
        k = cyc - m_t0;
        e_wrn  = !(m_phase == 2 && !m_rd && k >= S && k < S + T);
        e_rdn  = !(m_phase == 2 &&  m_rd && k >= S && k < S + T);
        e_txv  = (m_phase == 3);
        e_busy = (m_phase != 0);
        e_rxr  = (m_phase == 0 || m_phase == 1);
        m_valid = 1'b1;
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge CLK) begin
        if (m_valid) begin
            checks++;
            if ({TX_DATA, TX_VALID, RX_READY, DBG_DOUT, DBG_ADDR, DBG_WRN, DBG_RDN, BUSY, CMD_ERR, TIMEOUT_ERR} !==
                {e_txd, e_txv, e_rxr, e_dout, e_addr, e_wrn, e_rdn, e_busy, e_cerr, e_terr}) begin
                errors++;
                $display("FAIL model cyc=%0d actual txd=%h txv=%b rxr=%b dout=%h addr=%h wrn=%b rdn=%b busy=%b cerr=%b terr=%b required txd=%h txv=%b rxr=%b dout=%h addr=%h wrn=%b rdn=%b busy=%b cerr=%b terr=%b",
                         cyc, TX_DATA, TX_VALID, RX_READY, DBG_DOUT, DBG_ADDR, DBG_WRN, DBG_RDN, BUSY, CMD_ERR, TIMEOUT_ERR,
                         e_txd, e_txv, e_rxr, e_dout, e_addr, e_wrn, e_rdn, e_busy, e_cerr, e_terr);
            end
        end
    end

    always @(negedge CLK) begin
        if (DBG_WRN === 1'b0) begin wr_low++; if (wr_first < 0) wr_first = cyc; end
        if (DBG_RDN === 1'b0) begin rd_low++; if (rd_first < 0) rd_first = cyc; end
        if (TX_VALID === 1'b1) txv_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        wr_low = 0; rd_low = 0; wr_first = -1; rd_first = -1; txv_cnt = 0;
    endtask

    // Call at a falling edge; returns at the falling edge after the accept edge.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        RX_DATA = b;
        RX_VALID = 1'b1;
        while (RX_READY !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
        if (n >= 200) begin errors++; checks++; $display("FAIL rx_accept_timeout byte=%h", b); end
        @(posedge CLK);
        #1 acc = cyc;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    // Waits (bounded) for TX_VALID at a falling edge; reports byte and edge number.
    task automatic wait_tx(output logic [7:0] d, output int vc);
        int n;
        n = 0;
        while (TX_VALID !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
        if (n >= 200) begin errors++; checks++; $display("FAIL tx_wait_timeout actual=0 required=1"); end
        d = TX_DATA;
        vc = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, vc;
        logic [7:0] d;

        // Reset held for two edges.
        @(negedge CLK); @(negedge CLK);
        check("rst_wrn", DBG_WRN, 1); check("rst_rdn", DBG_RDN, 1);
        check("rst_addr", DBG_ADDR, 0); check("rst_dout", DBG_DOUT, 0);
        check("rst_txv", TX_VALID, 0); check("rst_busy", BUSY, 0);
        check("rst_cerr", CMD_ERR, 0); check("rst_terr", TIMEOUT_ERR, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Write 0x56 to register 3.
        clr_mon();
        send_byte(8'h03, c1);
        send_byte(8'h56, c2);
        wait_tx(d, vc);
        check("wr_ack", d, 8'h06);
        check("wr_ack_lat", vc - c2, 12);
        check("wr_addr", DBG_ADDR, 3);
        check("wr_dout", DBG_DOUT, 8'h56);
        check("wr_low_cnt", wr_low, 4);
        check("wr_first", wr_first - c2, 4);
        check("wr_no_rd", rd_low, 0);
        @(negedge CLK);
        check("wr_busy_end", BUSY, 0);

        // Read register 5 with the transmitter stalled.
        clr_mon();
        TX_READY = 1'b0;
        DBG_DIN = 8'hBB;
        send_byte(8'h85, c1);
        wait_tx(d, vc);
        check("rd_data", d, 8'hBB);
        check("rd_lat", vc - c1, 12);
        check("rd_addr", DBG_ADDR, 5);
        check("rd_low_cnt", rd_low, 4);
        check("rd_first", rd_first - c1, 4);
        DBG_DIN = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("rd_hold_txv", TX_VALID, 1);
            check("rd_hold_txd", TX_DATA, 8'hBB);
        end
        TX_READY = 1'b1;
        @(negedge CLK);
        check("rd_busy_end", BUSY, 0);

        // Invalid command, then error clearing.
        clr_mon();
        send_byte(8'h48, c1);
        wait_tx(d, vc);
        check("nak_byte", d, 8'h15);
        check("nak_cerr", CMD_ERR, 1);
        @(negedge CLK);
        check("nak_no_strobe", wr_low + rd_low, 0);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        check("clr_cerr", CMD_ERR, 0);
        CLR_ERR = 1'b1;
        send_byte(8'h48, c1);
        CLR_ERR = 1'b0;
        check("set_beats_clr", CMD_ERR, 1);
        wait_tx(d, vc);
        @(negedge CLK);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;

        // Write command with no data byte times out after TO cycles.
        clr_mon();
        send_byte(8'h01, c1);
        repeat (TO - 1) @(negedge CLK);
        check("to_before", TIMEOUT_ERR, 0);
        @(negedge CLK);
        check("to_edge", cyc - c1, TO);
        check("to_set", TIMEOUT_ERR, 1);
        check("to_idle", BUSY, 0);
        check("to_no_wrn", wr_low, 0);
        DBG_DIN = 8'h3C;
        send_byte(8'h81, c1);
        wait_tx(d, vc);
        check("to_next_read", d, 8'h3C);
        check("to_next_lat", vc - c1, 12);
        check("to_next_rdlow", rd_low, 4);
        @(negedge CLK);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;

        // Reset during the second cycle of the write strobe.
        clr_mon();
        send_byte(8'h02, c1);
        send_byte(8'h77, c2);
        while (cyc < c2 + 5) @(negedge CLK);
        check("mid_wrn_low", DBG_WRN, 0);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mid_wrn", DBG_WRN, 1);
        check("mid_txv", TX_VALID, 0);
        check("mid_busy", BUSY, 0);
        check("mid_addr", DBG_ADDR, 0);
        txv_cnt = 0;
        repeat (20) @(negedge CLK);
        check("mid_no_ack", txv_cnt, 0);
        clr_mon();
        DBG_DIN = 8'hA5;
        send_byte(8'h84, c1);
        wait_tx(d, vc);
        check("post_rd_data", d, 8'hA5);
        check("post_rd_addr", DBG_ADDR, 4);
        check("post_rd_lat", vc - c1, 12);
        @(negedge CLK);
        check("post_rd_idle", BUSY, 0);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
